mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Memory-stage load/store unit of the 5-stage RISC-V pipeline; sits between the EX/MEM register and the MEM/WB register.
- Converts the MEM-stage address, store data and funct3 into a word-aligned request on the data-memory bus, using a req/ack handshake.
- Stalls the pipeline while an access is outstanding.
- Returns the sign- or zero-extended load data as MemDout_mem, which the MEM/WB register captures.

Parameters:
- TIMEOUT, 16: maximum BUSY cycles to wait for dmem_ack before a bus error is flagged.

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- valid_mem  in  1  MEM-stage instruction is valid (not a bubble)
- MemRead_mem  in  1  instruction is a load
- MemWrite_mem  in  1  instruction is a store
- funct3_mem  in  3  access size and sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- ALUResult_mem  in  32  effective byte address
- MemDin_mem  in  32  store data (rs2 value)
- dmem_req  out  1  bus request; held high until acknowledged
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word address, {ALUResult_mem[31:2],2'b00}
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-aligned write data
- dmem_ack  in  1  single-cycle completion strobe from memory
- dmem_rdata  in  32  read word; valid in the cycle dmem_ack is high
- MemDout_mem  out  32  formatted load result, to MEM/WB
- mem_stall  out  1  freezes PC, IF/ID, ID/EX and EX/MEM; hazard logic inserts a bubble into MEM/WB
- misalign_exc  out  1  misaligned access detected (combinational, IDLE only)
- bus_err  out  1  one-cycle pulse on timeout

Behaviour:
- Reset: async, rst_n low. State returns to IDLE; dmem_req, dmem_we and bus_err go to 0; dmem_addr, dmem_be and dmem_wdata go to 0; MemDout_mem goes to 0; timeout counter goes to 0. An outstanding request is abandoned, and a late dmem_ack after reset is ignored.
- access = valid_mem & (MemRead_mem | MemWrite_mem). If MemRead_mem and MemWrite_mem are both high, the access is a store.
- Misalignment:
  - H/HU with addr[0] = 1 is misaligned.
  - W with addr[1:0] != 0 is misaligned.
  - In that case misalign_exc = 1 in IDLE, no request is issued, and there is no stall.
- Undefined funct3 values are treated as W.
- Store lanes:
  - SB: be = 4'b0001 << addr[1:0]; wdata = {4{MemDin[7:0]}}.
  - SH: be = 4'b0011 << {addr[1],1'b0}; wdata = {2{MemDin[15:0]}}.
  - SW: be = 4'b1111; wdata = MemDin.
  - Loads drive be = 4'b1111 and we = 0.
- Load format: select byte/half from dmem_rdata by addr[1:0]. B/H sign-extend; BU/HU zero-extend; W passes through.
- FSM IDLE / BUSY / DONE:
  - IDLE: if access & aligned, mem_stall = 1 (combinational). On the clock edge: latch addr/we/be/wdata/funct3/addr[1:0], set dmem_req = 1, clear the counter, and go to BUSY. Otherwise stay in IDLE with mem_stall = 0. dmem_ack is ignored in IDLE.
  - BUSY: mem_stall = 1; dmem_req and bus fields are held stable.
    - If dmem_ack: drop req; on a load, register the formatted data into MemDout_mem; go to DONE.
    - Else, if counter == TIMEOUT-1: drop req, pulse bus_err for one cycle, set MemDout_mem = 0, go to DONE.
    - Else: increment the counter.
  - DONE: mem_stall = 0 for one cycle; the pipeline advances and MEM/WB captures MemDout_mem. Go to IDLE unconditionally. A new access cannot start in DONE, because the next instruction enters MEM at the following edge.
- Latency: request visible 1 cycle after the access enters MEM. With ack in the same cycle, there are 2 stall cycles and the result is valid in the 3rd cycle.
- MemDout_mem holds its value except on a load ack or a timeout.
- Non-memory instructions and bubbles: no request, no stall, single-cycle pass.

Test Plan:
- LW at 0x100, memory returns 0xDEADBEEF with ack in the first BUSY cycle -> dmem_addr = 0x100, be = 1111, we = 0; mem_stall high 2 cycles; MemDout_mem = 0xDEADBEEF in DONE.
- LB at 0x103 and LBU at 0x103, rdata = 0x80FF_0000 -> LB gives 0xFFFFFF80; LBU gives 0x00000080.
- SH at 0x206, MemDin = 0x1234ABCD -> dmem_addr = 0x204, be = 1100, wdata = 0xABCDABCD, we = 1; MemDout_mem unchanged.
- LW at 0x102 -> misalign_exc = 1; dmem_req stays 0; mem_stall = 0.
- Load with TIMEOUT = 16 and no ack -> req high exactly 16 cycles; bus_err pulses once; MemDout_mem = 0; state returns to IDLE.
- rst_n low during BUSY with ack arriving 1 cycle later -> req = 0 immediately, state IDLE, MemDout_mem = 0; the late ack has no effect.

Source files
------------

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit for the 5-stage RISC-V pipeline.
// It turns the MEM-stage address, store data and funct3 into a word-aligned
// req/ack bus transaction, stalls the pipeline while the access is in flight,
// and returns the extended load result to the MEM/WB register.
module mem_access_unit #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_mem,
  input  logic        MemRead_mem,
  input  logic        MemWrite_mem,
  input  logic [2:0]  funct3_mem,
  input  logic [31:0] ALUResult_mem,
  input  logic [31:0] MemDin_mem,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] MemDout_mem,
  output logic        mem_stall,
  output logic        misalign_exc,
  output logic        bus_err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  // Access size code: 0 = byte, 1 = half, 2 = word (undefined codes act as word).
  function automatic logic [1:0] size_of(input logic [1:0] f3_lo);
    case (f3_lo)
      2'b00:   size_of = 2'd0;
      2'b01:   size_of = 2'd1;
      default: size_of = 2'd2;
    endcase
  endfunction

  // Byte enables for a store of the given size at the given byte offset.
  function automatic logic [3:0] store_be(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'd0:    store_be = 4'b0001 << off;
      2'd1:    store_be = 4'b0011 << {off[1], 1'b0};
      default: store_be = 4'b1111;
    endcase
  endfunction

  // Replicate the store operand so every candidate lane carries it.
  function automatic logic [31:0] store_wdata(input logic [1:0] sz, input logic [31:0] din);
    case (sz)
      2'd0:    store_wdata = {4{din[7:0]}};
      2'd1:    store_wdata = {2{din[15:0]}};
      default: store_wdata = din;
    endcase
  endfunction

  // Pick the addressed byte/half from the read word and extend it; bit 2 of
  // funct3 selects zero-extension.
  function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] rdata);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] sx;
    b  = rdata[{off, 3'b000} +: 8];
    h  = rdata[{off[1], 4'b0000} +: 16];
    sx = rdata;
    case (size_of(f3[1:0]))
      2'd0:    sx = f3[2] ? $signed({24'd0, b}) : 32'(b);
      2'd1:    sx = f3[2] ? $signed({16'd0, h}) : 32'(h);
      default: sx = $signed(rdata);
    endcase
    fmt_load = sx;
  endfunction

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       f3_p1;
  logic [1:0]       off_p1;

  logic       access;
  logic       is_store;
  logic [1:0] size_p0;
  logic       misaligned;

  // Decode the incoming access and produce the combinational stall/exception.
  always_comb begin
    access     = valid_mem & (MemRead_mem | MemWrite_mem);
    is_store   = MemWrite_mem;
    size_p0    = size_of(funct3_mem[1:0]);
    misaligned = ((size_p0 == 2'd1) & ALUResult_mem[0]) |
                 ((size_p0 == 2'd2) & (ALUResult_mem[1:0] != 2'b00));
    misalign_exc = (state == ST_IDLE) & access & misaligned;
    mem_stall    = ((state == ST_IDLE) & access & ~misaligned) | (state == ST_BUSY);
  end

  // Request FSM: launch from IDLE, wait for ack or timeout in BUSY, release in DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      dmem_req    <= 1'b0;
      dmem_we     <= 1'b0;
      dmem_addr   <= '0;
      dmem_be     <= '0;
      dmem_wdata  <= '0;
      f3_p1       <= '0;
      off_p1      <= '0;
      MemDout_mem <= '0;
      bus_err     <= 1'b0;
    end else begin
      bus_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (access && !misaligned) begin
            state      <= ST_BUSY;
            cnt        <= '0;
            dmem_req   <= 1'b1;
            dmem_we    <= is_store;
            dmem_addr  <= {ALUResult_mem[31:2], 2'b00};
            dmem_be    <= is_store ? store_be(size_p0, ALUResult_mem[1:0]) : 4'b1111;
            dmem_wdata <= is_store ? store_wdata(size_p0, MemDin_mem) : 32'd0;
            f3_p1      <= funct3_mem;
            off_p1     <= ALUResult_mem[1:0];
          end
        end
        ST_BUSY: begin
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            if (!dmem_we) MemDout_mem <= fmt_load(f3_p1, off_p1, dmem_rdata);
            state    <= ST_DONE;
          end else if (cnt == CNT_LAST) begin
            dmem_req    <= 1'b0;
            bus_err     <= 1'b1;
            MemDout_mem <= '0;
            state       <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed table of accesses, randomized accesses
// against an arithmetic reference model, and hand sequences for timeout and
// reset-during-request.
module tb_mem_access_unit;

  logic        clk;
  logic        rst_n;
  logic        valid_mem;
  logic        MemRead_mem;
  logic        MemWrite_mem;
  logic [2:0]  funct3_mem;
  logic [31:0] ALUResult_mem;
  logic [31:0] MemDin_mem;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic [31:0] MemDout_mem;
  logic        mem_stall;
  logic        misalign_exc;
  logic        bus_err;

  mem_access_unit #(.TIMEOUT(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .valid_mem    (valid_mem),
    .MemRead_mem  (MemRead_mem),
    .MemWrite_mem (MemWrite_mem),
    .funct3_mem   (funct3_mem),
    .ALUResult_mem(ALUResult_mem),
    .MemDin_mem   (MemDin_mem),
    .dmem_req     (dmem_req),
    .dmem_we      (dmem_we),
    .dmem_addr    (dmem_addr),
    .dmem_be      (dmem_be),
    .dmem_wdata   (dmem_wdata),
    .dmem_ack     (dmem_ack),
    .dmem_rdata   (dmem_rdata),
    .MemDout_mem  (MemDout_mem),
    .mem_stall    (mem_stall),
    .misalign_exc (misalign_exc),
    .bus_err      (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] model_dout = 32'd0;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] rdata;
    int          dly;
    logic        e_mis;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wd;
    logic        e_we;
    logic [31:0] e_ld;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // Reference model: expectations computed from byte counts and plain arithmetic.
  task automatic ref_model(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] din,
                           input logic [31:0] rdata, output vec_t v);
    int nb;
    int idx;
    logic [63:0] val;
    logic [63:0] lim;
    nb  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    idx = int'(addr % 4);
    v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.din = din; v.rdata = rdata;
    v.dly    = 0;
    v.e_mis  = (addr % nb) != 0;
    v.e_addr = addr - (addr % 4);
    v.e_we   = wr;
    if (wr) begin
      v.e_be = 4'(((1 << nb) - 1) << idx);
      if (nb == 1)      v.e_wd = (din & 32'hFF) * 32'h0101_0101;
      else if (nb == 2) v.e_wd = (din & 32'hFFFF) * 32'h0001_0001;
      else              v.e_wd = din;
    end else begin
      v.e_be = 4'hF;
      v.e_wd = 32'd0;
    end
    if (nb == 4) begin
      v.e_ld = rdata;
    end else begin
      lim = 64'd1 << (8 * nb);
      val = (64'(rdata) >> (8 * idx)) % lim;
      if (!f3[2] && val >= lim / 2) val = val + (64'hFFFF_FFFF_FFFF_FFFF - lim + 1);
      v.e_ld = val[31:0];
    end
  endtask

  // One MEM-stage access from entry through DONE, with the memory acking after dly cycles.
  task automatic do_access(input vec_t v, input string tag);
    valid_mem     = 1'b1;
    MemRead_mem   = v.rd;
    MemWrite_mem  = v.wr;
    funct3_mem    = v.f3;
    ALUResult_mem = v.addr;
    MemDin_mem    = v.din;
    #1;
    chk({tag, " misalign_exc"}, 32'(misalign_exc), 32'(v.e_mis));
    chk({tag, " stall_entry"}, 32'(mem_stall), 32'(!v.e_mis));
    @(posedge clk); #1;
    if (v.e_mis) begin
      chk({tag, " req_misaligned"}, 32'(dmem_req), 32'd0);
      chk({tag, " stall_misaligned"}, 32'(mem_stall), 32'd0);
      valid_mem = 1'b0;
      @(posedge clk); #1;
    end else begin
      chk({tag, " req"}, 32'(dmem_req), 32'd1);
      chk({tag, " addr"}, dmem_addr, v.e_addr);
      chk({tag, " be"}, 32'(dmem_be), 32'(v.e_be));
      chk({tag, " we"}, 32'(dmem_we), 32'(v.e_we));
      if (v.wr) chk({tag, " wdata"}, dmem_wdata, v.e_wd);
      for (int i = 0; i < v.dly; i++) begin
        chk({tag, " stall_busy"}, 32'(mem_stall), 32'd1);
        @(posedge clk); #1;
        chk({tag, " req_hold"}, 32'(dmem_req), 32'd1);
        chk({tag, " addr_hold"}, dmem_addr, v.e_addr);
      end
      chk({tag, " stall_ack"}, 32'(mem_stall), 32'd1);
      dmem_ack   = 1'b1;
      dmem_rdata = v.rdata;
      @(posedge clk); #1;
      dmem_ack   = 1'b0;
      dmem_rdata = $urandom;
      if (!v.wr) model_dout = v.e_ld;
      chk({tag, " dout"}, MemDout_mem, model_dout);
      chk({tag, " stall_done"}, 32'(mem_stall), 32'd0);
      chk({tag, " req_done"}, 32'(dmem_req), 32'd0);
      valid_mem = 1'b0;
      @(posedge clk); #1;
      chk({tag, " stall_idle"}, 32'(mem_stall), 32'd0);
    end
  endtask

  vec_t tbl[12];

  initial begin
    vec_t v;
    int   nreq;
    int   nerr;

    tbl[0]  = '{1'b1, 1'b0, 3'b010, 32'h100, 32'h0,        32'hDEADBEEF, 0, 1'b0, 32'h100, 4'hF, 32'h0,        1'b0, 32'hDEADBEEF};
    tbl[1]  = '{1'b1, 1'b0, 3'b000, 32'h103, 32'h0,        32'h80FF0000, 1, 1'b0, 32'h100, 4'hF, 32'h0,        1'b0, 32'hFFFFFF80};
    tbl[2]  = '{1'b1, 1'b0, 3'b100, 32'h103, 32'h0,        32'h80FF0000, 0, 1'b0, 32'h100, 4'hF, 32'h0,        1'b0, 32'h00000080};
    tbl[3]  = '{1'b0, 1'b1, 3'b001, 32'h206, 32'h1234ABCD, 32'h0,        2, 1'b0, 32'h204, 4'hC, 32'hABCDABCD, 1'b1, 32'h0};
    tbl[4]  = '{1'b1, 1'b0, 3'b010, 32'h102, 32'h0,        32'h0,        0, 1'b1, 32'h100, 4'hF, 32'h0,        1'b0, 32'h0};
    tbl[5]  = '{1'b0, 1'b1, 3'b000, 32'h101, 32'h000000A5, 32'h0,        0, 1'b0, 32'h100, 4'h2, 32'hA5A5A5A5, 1'b1, 32'h0};
    tbl[6]  = '{1'b1, 1'b0, 3'b001, 32'h102, 32'h0,        32'h80011234, 1, 1'b0, 32'h100, 4'hF, 32'h0,        1'b0, 32'hFFFF8001};
    tbl[7]  = '{1'b1, 1'b0, 3'b101, 32'h102, 32'h0,        32'h80011234, 0, 1'b0, 32'h100, 4'hF, 32'h0,        1'b0, 32'h00008001};
    tbl[8]  = '{1'b1, 1'b0, 3'b001, 32'h101, 32'h0,        32'h0,        0, 1'b1, 32'h100, 4'hF, 32'h0,        1'b0, 32'h0};
    tbl[9]  = '{1'b0, 1'b1, 3'b010, 32'h300, 32'hCAFEF00D, 32'h0,        3, 1'b0, 32'h300, 4'hF, 32'hCAFEF00D, 1'b1, 32'h0};
    tbl[10] = '{1'b1, 1'b1, 3'b000, 32'h003, 32'h00000077, 32'h0,        0, 1'b0, 32'h000, 4'h8, 32'h77777777, 1'b1, 32'h0};
    tbl[11] = '{1'b1, 1'b0, 3'b011, 32'h010, 32'h0,        32'h0BADF00D, 1, 1'b0, 32'h010, 4'hF, 32'h0,        1'b0, 32'h0BADF00D};

    rst_n = 1'b0; valid_mem = 1'b0; MemRead_mem = 1'b0; MemWrite_mem = 1'b0;
    funct3_mem = 3'b0; ALUResult_mem = 32'h0; MemDin_mem = 32'h0;
    dmem_ack = 1'b0; dmem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst req", 32'(dmem_req), 32'd0);
    chk("rst we", 32'(dmem_we), 32'd0);
    chk("rst addr", dmem_addr, 32'd0);
    chk("rst be", 32'(dmem_be), 32'd0);
    chk("rst wdata", dmem_wdata, 32'd0);
    chk("rst dout", MemDout_mem, 32'd0);
    chk("rst bus_err", 32'(bus_err), 32'd0);
    chk("rst stall", 32'(mem_stall), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Non-memory instruction and a load-flagged bubble: single-cycle pass.
    valid_mem = 1'b1; MemRead_mem = 1'b0; MemWrite_mem = 1'b0; ALUResult_mem = 32'h100;
    #1 chk("alu stall", 32'(mem_stall), 32'd0);
    @(posedge clk); #1;
    chk("alu req", 32'(dmem_req), 32'd0);
    valid_mem = 1'b0; MemRead_mem = 1'b1;
    #1 chk("bubble stall", 32'(mem_stall), 32'd0);
    @(posedge clk); #1;
    chk("bubble req", 32'(dmem_req), 32'd0);
    MemRead_mem = 1'b0;

    for (int i = 0; i < 12; i++) do_access(tbl[i], $sformatf("vec%0d", i));

    for (int i = 0; i < 40; i++) begin
      logic rd;
      logic wr;
      rd = 1'($urandom_range(0, 1));
      wr = rd ? 1'($urandom_range(0, 1)) : 1'b1;
      ref_model(rd, wr, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom, v);
      v.dly = $urandom_range(0, 3);
      do_access(v, $sformatf("rnd%0d", i));
    end

    // Timeout: load with no ack; MemDout_mem is nonzero beforehand.
    ref_model(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 32'h55AA55AA, v);
    do_access(v, "pre_timeout");
    valid_mem = 1'b1; MemRead_mem = 1'b1; MemWrite_mem = 1'b0;
    funct3_mem = 3'b010; ALUResult_mem = 32'h44;
    @(posedge clk); #1;
    nreq = 0; nerr = 0;
    for (int k = 0; k < 24; k++) begin
      if (dmem_req) nreq++;
      if (bus_err) begin
        nerr++;
        model_dout = 32'd0;
        chk("timeout dout", MemDout_mem, model_dout);
        chk("timeout stall", 32'(mem_stall), 32'd0);
        valid_mem = 1'b0;
      end
      @(posedge clk); #1;
    end
    chk("timeout req cycles", 32'(nreq), 32'd16);
    chk("timeout bus_err pulses", 32'(nerr), 32'd1);
    chk("timeout back idle", 32'(mem_stall), 32'd0);
    valid_mem = 1'b0;

    // Reset while BUSY, then a late ack that must be ignored.
    ref_model(1'b1, 1'b0, 3'b010, 32'h80, 32'h0, 32'h11112222, v);
    do_access(v, "pre_reset");
    valid_mem = 1'b1; MemRead_mem = 1'b1; MemWrite_mem = 1'b0;
    funct3_mem = 3'b010; ALUResult_mem = 32'h84;
    @(posedge clk); #1;
    chk("busy before reset req", 32'(dmem_req), 32'd1);
    rst_n = 1'b0; valid_mem = 1'b0;
    #1;
    model_dout = 32'd0;
    chk("reset busy req", 32'(dmem_req), 32'd0);
    chk("reset busy dout", MemDout_mem, model_dout);
    chk("reset busy stall", 32'(mem_stall), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    dmem_ack = 1'b1; dmem_rdata = 32'h12345678;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    chk("late ack req", 32'(dmem_req), 32'd0);
    chk("late ack dout", MemDout_mem, model_dout);
    chk("late ack stall", 32'(mem_stall), 32'd0);
    chk("late ack bus_err", 32'(bus_err), 32'd0);

    ref_model(1'b1, 1'b0, 3'b100, 32'h91, 32'h0, 32'hA1B2C3D4, v);
    do_access(v, "post_reset");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
